// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB controller for an RV32I subset (R, I-ALU, LW, SW, BEQ).
// Decode (ALUSrc/ALUCtrl) is combinational; strobes are registered and only MEM can stall.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        dReady,
    output logic        PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [3:0]  ALUCtrl,
    output logic        loadPC,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        illegal,
    output logic        mem_tmo,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     st;
    logic [7:0] cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_lw, is_sw, is_beq, legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign state  = st;

    always_comb begin
        is_r   = (opcode == OP_R);
        is_i   = (opcode == OP_I);
        is_lw  = (opcode == OP_LW)  && (funct3 == 3'b010);
        is_sw  = (opcode == OP_SW)  && (funct3 == 3'b010);
        is_beq = (opcode == OP_BEQ) && (funct3 == 3'b000);
        legal  = is_r || is_i || is_lw || is_sw || is_beq;
    end

    // Operand/ALU select follow the opcode even for illegal encodings of a known opcode.
    always_comb begin
        ALUSrc  = (opcode == OP_I) || (opcode == OP_LW) || (opcode == OP_SW);
        ALUCtrl = 4'b0010;
        if (opcode == OP_BEQ) begin
            ALUCtrl = 4'b0110;
        end else if (is_r || is_i) begin
            case (funct3)
                3'b000:  ALUCtrl = (is_r && instr[30]) ? 4'b0110 : 4'b0010;
                3'b001:  ALUCtrl = 4'b1001;
                3'b010:  ALUCtrl = 4'b0111;
                3'b011:  ALUCtrl = 4'b1011;
                3'b100:  ALUCtrl = 4'b1101;
                3'b101:  ALUCtrl = instr[30] ? 4'b1010 : 4'b1000;
                3'b110:  ALUCtrl = 4'b0001;
                default: ALUCtrl = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_IF;
            cnt      <= 8'd0;
            PCSrc    <= 1'b0;
            RegWrite <= 1'b0;
            MemToReg <= 1'b0;
            loadPC   <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            illegal  <= 1'b0;
            mem_tmo  <= 1'b0;
        end else begin
            PCSrc    <= 1'b0;
            RegWrite <= 1'b0;
            MemToReg <= 1'b0;
            loadPC   <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            illegal  <= 1'b0;
            mem_tmo  <= 1'b0;
            case (st)
                S_IF: begin
                    st      <= S_ID;
                    illegal <= !legal;
                end
                S_ID: st <= S_EX;
                S_EX: begin
                    st       <= S_MEM;
                    cnt      <= 8'd0;
                    MemRead  <= is_lw;
                    MemWrite <= is_sw;
                end
                S_MEM: begin
                    if ((MemRead || MemWrite) && !dReady) begin
                        if (cnt == WAIT_LAST) begin
                            // Timed-out access: finish the instruction but never write back.
                            st      <= S_WB;
                            mem_tmo <= 1'b1;
                            loadPC  <= 1'b1;
                        end else begin
                            cnt      <= cnt + 8'd1;
                            MemRead  <= MemRead;
                            MemWrite <= MemWrite;
                        end
                    end else begin
                        st       <= S_WB;
                        loadPC   <= 1'b1;
                        RegWrite <= is_r || is_i || is_lw;
                        MemToReg <= is_lw;
                        PCSrc    <= is_beq && Zero;
                    end
                end
                default: begin
                    st  <= S_IF;
                    cnt <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: stimulus pushes expected per-instruction WB records, a monitor checks at each loadPC.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        Zero = 1'b0;
    logic        dReady = 1'b0;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal, mem_tmo;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;

    multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst), .instr(instr), .Zero(Zero), .dReady(dReady),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUCtrl(ALUCtrl), .loadPC(loadPC), .MemRead(MemRead), .MemWrite(MemWrite),
        .illegal(illegal), .mem_tmo(mem_tmo), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        bit       rw, m2r, pcs, asrc;
        bit [3:0] alu;
        int       rd_cyc, wr_cyc, ill, tmo, len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // Monitor: accumulates per-instruction activity, compares when the DUT presents WB (loadPC).
    int cyc, rdc, wrc, illc, tmoc, bad, prev;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cyc = 0; rdc = 0; wrc = 0; illc = 0; tmoc = 0; bad = 0; prev = 4;
        end else begin
            cyc++;
            rdc  += int'(MemRead);
            wrc  += int'(MemWrite);
            illc += int'(illegal);
            tmoc += int'(mem_tmo);
            if ((MemRead && MemWrite) || ((MemRead || MemWrite) && state != 3'd3)) bad++;
            if (!((int'(state) == ((prev == 4) ? 0 : prev + 1)) || (state == 3'd3 && prev == 3))) bad++;
            prev = int'(state);
            if (loadPC) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, ".state"},    int'(state),    4);
                    chk({e.name, ".RegWrite"}, int'(RegWrite), int'(e.rw));
                    chk({e.name, ".MemToReg"}, int'(MemToReg), int'(e.m2r));
                    chk({e.name, ".PCSrc"},    int'(PCSrc),    int'(e.pcs));
                    chk({e.name, ".ALUSrc"},   int'(ALUSrc),   int'(e.asrc));
                    chk({e.name, ".ALUCtrl"},  int'(ALUCtrl),  int'(e.alu));
                    chk({e.name, ".memread_cycles"},  rdc,  e.rd_cyc);
                    chk({e.name, ".memwrite_cycles"}, wrc,  e.wr_cyc);
                    chk({e.name, ".illegal_pulses"},  illc, e.ill);
                    chk({e.name, ".mem_tmo_pulses"},  tmoc, e.tmo);
                    chk({e.name, ".cycles"},          cyc,  e.len);
                    chk({e.name, ".seq_violations"},  bad,  0);
                end
                cyc = 0; rdc = 0; wrc = 0; illc = 0; tmoc = 0; bad = 0;
            end
        end
    end

    // Issue one instruction in IF; dReady rises on MEM cycle rdy_at (0 = never).
    task automatic run(input logic [31:0] ins, input logic z, input int rdy_at, input exp_t e);
        int  k = 0;
        bit  done = 0;
        int  budget = 0;
        @(negedge clk);
        while (state != 3'd0 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        instr = ins;
        Zero  = z;
        exp_q.push_back(e);
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (state == 3'd3) begin
                k++;
                dReady = (k == rdy_at);
            end else begin
                dReady = 1'b0;
            end
            if (loadPC) done = 1;
        end
        dReady = 1'b0;
        if (!done) chk({e.name, ".wb_timeout"}, 0, 1);
    endtask

    function automatic exp_t mk(input string n, input bit rw, input bit m2r, input bit pcs,
                                input bit asrc, input bit [3:0] alu, input int rd, input int wr,
                                input int ill, input int tmo, input int len);
        exp_t e;
        e.name = n; e.rw = rw; e.m2r = m2r; e.pcs = pcs; e.asrc = asrc; e.alu = alu;
        e.rd_cyc = rd; e.wr_cyc = wr; e.ill = ill; e.tmo = tmo; e.len = len;
        return e;
    endfunction

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst.state", int'(state), 0);
        chk("rst.strobes", int'({PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal, mem_tmo}), 0);
        chk("rst.ALUCtrl", int'(ALUCtrl), 4'b0010);
        @(posedge clk); #1 rst = 1'b0;

        run(32'h002081B3, 1'b0, 0, mk("add",   1, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 5));
        run(32'h00812283, 1'b0, 3, mk("lw_w3", 1, 1, 0, 1, 4'b0010, 3, 0, 0, 0, 7));
        run(32'h00812283, 1'b0, 1, mk("lw_w1", 1, 1, 0, 1, 4'b0010, 1, 0, 0, 0, 5));
        run(32'h00208463, 1'b1, 0, mk("beq_z1", 0, 0, 1, 0, 4'b0110, 0, 0, 0, 0, 5));
        run(32'h00208463, 1'b0, 0, mk("beq_z0", 0, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 5));
        run(32'h0000007F, 1'b1, 1, mk("illop", 0, 0, 0, 0, 4'b0010, 0, 0, 1, 0, 5));
        run(32'h00813283, 1'b0, 1, mk("lw_f3", 0, 0, 0, 1, 4'b0010, 0, 0, 1, 0, 5));
        run(32'h00209463, 1'b1, 0, mk("beq_f3", 0, 0, 0, 0, 4'b0110, 0, 0, 1, 0, 5));
        run(32'h00020A223 & 32'hFFFFFFFF, 1'b0, 0, mk("sw_tmo", 0, 0, 0, 1, 4'b0010, 0, 15, 0, 1, 19));
        run(32'h00020A223 & 32'hFFFFFFFF, 1'b0, 2, mk("sw_w2", 0, 0, 0, 1, 4'b0010, 0, 2, 0, 0, 6));
        run(32'h40208133, 1'b0, 0, mk("sub",   1, 0, 0, 0, 4'b0110, 0, 0, 0, 0, 5));
        run(32'h40315093, 1'b0, 0, mk("srai",  1, 0, 0, 1, 4'b1010, 0, 0, 0, 0, 5));
        run(32'h40000093, 1'b0, 0, mk("addi_b30", 1, 0, 0, 1, 4'b0010, 0, 0, 0, 0, 5));
        run(32'h0020C1B3, 1'b0, 0, mk("xor",   1, 0, 0, 0, 4'b1101, 0, 0, 0, 0, 5));

        // Reset during an LW MEM stall, then resume with a full instruction.
        @(negedge clk);
        instr = 32'h00812283;
        dReady = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (state == 3'd3) n++;
        end
        chk("stall.memread_before_rst", int'(MemRead), 1);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("stall_rst.state", int'(state), 0);
        chk("stall_rst.MemRead", int'(MemRead), 0);
        chk("stall_rst.RegWrite", int'(RegWrite), 0);
        chk("stall_rst.loadPC", int'(loadPC), 0);
        instr = 32'h002081B3;
        @(posedge clk); #1 rst = 1'b0;
        run(32'h002081B3, 1'b0, 0, mk("add_post_rst", 1, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 5));

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
